// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state
// encoding, NOP/HALT instruction encodings, word size and an address
// alignment helper.
package fetch_pkg;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_ENCODING  = 32'h0000_0000;
  localparam logic [31:0] HALT_ENCODING = 32'hFFFF_FFFF;
  localparam logic [31:0] WORD_BYTES    = 32'd4;

  // Clear the byte-offset bits so the PC always points at a whole word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter flop. Priority: reset, then load of a word-aligned
// redirect target, then increment by one word; otherwise the value holds.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_value,
  input  logic        inc_en,
  output logic [31:0] pc
);

  logic [31:0] pc_reg;

  // PC update: reset > load > increment > hold; increment wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_VALUE;
    end else if (load_en) begin
      pc_reg <= word_align(load_value);
    end else if (inc_en) begin
      pc_reg <= pc_reg + WORD_BYTES;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, presents it as the instruction memory byte
// address, and registers the returned word into the IF/ID register.
// Handles stalls, flushes, redirects and a HALT park state.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch and stall counters.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = NOP_ENCODING,
  parameter logic [31:0] HALT_INSTR = HALT_ENCODING
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic [31:0] id_instr_o,
  output logic        id_valid_o,
  output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  fetch_state_t state_reg;
  logic [31:0]  pc;
  logic [31:0]  id_pc_reg;
  logic [31:0]  id_pc_plus4_reg;
  logic [31:0]  id_instr_reg;
  logic         id_valid_reg;
  logic         halted_reg;

  // Cycle classification. Redirect wins in both states; stall only matters in RUN.
  logic in_run;
  logic normal_adv;
  logic halt_hit;
  logic pc_inc;
  logic load_valid;

  assign in_run     = (state_reg == FETCH_RUN);
  assign normal_adv = in_run & ~redirect_valid_i & ~stall_i;
  assign halt_hit   = normal_adv & ~flush_i & (imem_instr_i == HALT_INSTR);
  assign pc_inc     = normal_adv & ~halt_hit;
  assign load_valid = pc_inc & ~flush_i;

  pc_register #(
    .RESET_VALUE(RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .rst       (rst),
    .load_en   (redirect_valid_i),
    .load_value(redirect_target_i),
    .inc_en    (pc_inc),
    .pc        (pc)
  );

  // RUN/HALT FSM together with the IF/ID register it controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FETCH_RUN;
      halted_reg      <= 1'b0;
      id_pc_reg       <= 32'h0000_0000;
      id_pc_plus4_reg <= 32'h0000_0004;
      id_instr_reg    <= NOP_INSTR;
      id_valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        FETCH_RUN: begin
          if (redirect_valid_i) begin
            id_valid_reg <= 1'b0;
            id_instr_reg <= NOP_INSTR;
          end else if (stall_i) begin
            if (flush_i) begin
              id_valid_reg <= 1'b0;
              id_instr_reg <= NOP_INSTR;
            end
          end else if (halt_hit) begin
            // The HALT word itself is swallowed; PC stays on it.
            state_reg    <= FETCH_HALT;
            halted_reg   <= 1'b1;
            id_valid_reg <= 1'b0;
            id_instr_reg <= NOP_INSTR;
          end else begin
            id_pc_reg       <= pc;
            id_pc_plus4_reg <= pc + WORD_BYTES;
            id_instr_reg    <= flush_i ? NOP_INSTR : imem_instr_i;
            id_valid_reg    <= ~flush_i;
          end
        end
        FETCH_HALT: begin
          id_valid_reg <= 1'b0;
          id_instr_reg <= NOP_INSTR;
          if (redirect_valid_i) begin
            state_reg  <= FETCH_RUN;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= FETCH_RUN;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  // Counters: delivered instructions, and RUN cycles lost to decode stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_reg <= 32'h0;
      stall_cnt_reg <= 32'h0;
    end else begin
      if (load_valid) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      if (in_run & stall_i & ~redirect_valid_i) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_reg;
  assign stall_cnt_o = stall_cnt_reg;
`endif

  assign imem_addr_o   = pc;
  assign id_pc_o       = id_pc_reg;
  assign id_pc_plus4_o = id_pc_plus4_reg;
  assign id_instr_o    = id_instr_reg;
  assign id_valid_o    = id_valid_reg;
  assign halted_o      = halted_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// stall/flush/redirect/reset traffic, compared against a cycle-level
// behavioural model of the fetch rules. Build with FETCH_PERF_CNT_EN to
// also check the counters.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] W_A  = 32'hA0A0_0001;
  localparam logic [31:0] W_B  = 32'hB0B0_0002;
  localparam logic [31:0] W_C  = 32'hC0C0_0003;
  localparam logic [31:0] W_D  = 32'hD0D0_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[11:2]];

  instruction_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .flush_i          (flush),
    .redirect_valid_i (redir),
    .redirect_target_i(target),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .id_pc_o          (id_pc),
    .id_pc_plus4_o    (id_pc_plus4),
    .id_instr_o       (id_instr),
    .id_valid_o       (id_valid),
    .halted_o         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o      (fetch_cnt),
    .stall_cnt_o      (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Behavioural model state: what the fetch stage should look like after each edge.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_id_pc = 32'h0;
  logic [31:0] m_id_pc4 = 32'h4;
  logic [31:0] m_id_instr = NOP;
  bit          m_valid = 1'b0;
  bit          m_halted = 1'b0;
  logic [31:0] m_fcnt = 32'h0;
  logic [31:0] m_scnt = 32'h0;

  // Apply one cycle of inputs, advance the model by the fetch rules, compare.
  task automatic step(input bit r, input bit s, input bit f, input bit rv, input logic [31:0] tgt);
    logic [31:0] word;
    rst = r; stall = s; flush = f; redir = rv; target = tgt;
    word = mem[m_pc[11:2]];
    if (r) begin
      m_pc = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h4; m_id_instr = NOP;
      m_valid = 1'b0; m_halted = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
    end else if (m_halted) begin
      if (rv) begin
        m_pc = {tgt[31:2], 2'b00};
        m_halted = 1'b0;
      end
    end else if (rv) begin
      m_pc = {tgt[31:2], 2'b00};
      m_valid = 1'b0; m_id_instr = NOP;
    end else if (s) begin
      m_scnt = m_scnt + 1;
      if (f) begin m_valid = 1'b0; m_id_instr = NOP; end
    end else if (word == HALT && !f) begin
      m_halted = 1'b1; m_valid = 1'b0; m_id_instr = NOP;
    end else begin
      m_id_pc = m_pc;
      m_id_pc4 = m_pc + 4;
      m_id_instr = f ? NOP : word;
      m_valid = !f;
      if (!f) m_fcnt = m_fcnt + 1;
      m_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rst=%0b stall=%0b flush=%0b redir=%0b tgt=%h | addr=%h id_pc=%h id_instr=%h valid=%0b halted=%0b",
             txn, r, s, f, rv, tgt, imem_addr, id_pc, id_instr, id_valid, halted);
    check("m_addr",   imem_addr, m_pc);
    check("m_valid",  {31'b0, id_valid}, {31'b0, m_valid});
    check("m_instr",  id_instr, m_id_instr);
    check("m_halted", {31'b0, halted}, {31'b0, m_halted});
    if (m_valid || r) begin
      check("m_id_pc",  id_pc, m_id_pc);
      check("m_id_pc4", id_pc_plus4, m_id_pc4);
    end
`ifdef FETCH_PERF_CNT_EN
    check("m_fcnt", fetch_cnt, m_fcnt);
    check("m_scnt", stall_cnt, m_scnt);
`endif
  endtask

  task automatic free_run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},   imem_addr, 32'h0);
    check({tag, "_id_pc"},  id_pc, 32'h0);
    check({tag, "_id_pc4"}, id_pc_plus4, 32'h4);
    check({tag, "_instr"},  id_instr, NOP);
    check({tag, "_valid"},  {31'b0, id_valid}, 32'h0);
    check({tag, "_halted"}, {31'b0, halted}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_fcnt"}, fetch_cnt, 32'h0);
    check({tag, "_scnt"}, stall_cnt, 32'h0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_words [0:3];
    logic [31:0] rt;
    int          rnd;
    exp_words[0] = W_A; exp_words[1] = W_B; exp_words[2] = W_C; exp_words[3] = W_D;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = W_A; mem[1] = W_B; mem[2] = W_C; mem[3] = W_D;
    #1;

    // 1: reset, then four sequential fetches
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_reset_values("t1_rst");
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", imem_addr, 32'(i * 4));
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("t1_instr", id_instr, exp_words[i]);
      check("t1_id_pc", id_pc, 32'(i * 4));
      check("t1_valid", {31'b0, id_valid}, 32'h1);
    end

    // 2: stall two cycles at pc=8, then release
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    free_run(2);
    check("t2_addr0", imem_addr, 32'h8);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("t2_hold_addr", imem_addr, 32'h8);
      check("t2_hold_instr", id_instr, W_B);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t2_instr_c", id_instr, W_C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t2_instr_d", id_instr, W_D);
`ifdef FETCH_PERF_CNT_EN
    check("t2_stall_cnt", stall_cnt, 32'd2);
`endif

    // 3: redirect with stall asserted; target low bits dropped
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h43);
    check("t3_addr", imem_addr, 32'h40);
    check("t3_valid", {31'b0, id_valid}, 32'h0);
    check("t3_instr", id_instr, NOP);

    // 4: HALT word at mem[2], then redirect out of HALT
    mem[2] = HALT;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    free_run(3);
    check("t4_halted", {31'b0, halted}, 32'h1);
    check("t4_addr", imem_addr, 32'h8);
    check("t4_valid", {31'b0, id_valid}, 32'h0);
    free_run(2);
    check("t4_frozen", imem_addr, 32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    check("t4_run", {31'b0, halted}, 32'h0);
    check("t4_addr_r", imem_addr, 32'h10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t4_instr", id_instr, 32'h1000_0004);
    check("t4_valid_r", {31'b0, id_valid}, 32'h1);

    // 5: PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t5_addr", imem_addr, 32'h0);
    check("t5_id_pc", id_pc, 32'hFFFF_FFFC);
    check("t5_id_pc4", id_pc_plus4, 32'h0);

    // 6: reset mid-stall and while halted (with a redirect pending)
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check_reset_values("t6_stall");
    free_run(3);
    check("t6_halted_pre", {31'b0, halted}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
    check_reset_values("t6_halt");
    mem[2] = W_C;

    // Random traffic over a small program region with occasional HALT words
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 19) == 0) ? HALT : $urandom;
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom_range(0, 99);
      rt  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      step(rnd < 2, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 9) == 0, rt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
